// File: rtl/if_stage_if.sv
// Instruction-memory fetch port between the IF stage and instruction memory.
// The master issues a read address; the slave answers with a one-cycle strobe.
interface if_stage_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;
  logic                 i_inputReady;

  modport master (
    output i_readM,
    output i_address,
    input  i_data,
    input  i_inputReady
  );

  modport slave (
    input  i_readM,
    input  i_address,
    output i_data,
    output i_inputReady
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single outstanding fetch, IF/ID register.
// A word arriving during a stall is parked in a buffer until ID can take it.
module if_stage #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  if_stage_if.master           imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic [WORD_SIZE-1:0] if_id_inst,
  output logic [WORD_SIZE-1:0] if_id_pc1,
  output logic                 if_id_valid
);

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_HALT
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] inst_q, inst_d;
  logic [WORD_SIZE-1:0] pc1_q, pc1_d;
  logic                 valid_q, valid_d;
  logic [WORD_SIZE-1:0] buf_q, buf_d;
  logic [WORD_SIZE-1:0] pc_inc;

  assign pc_inc         = pc_q + 1'b1;
  assign imem.i_address = pc_q;
  assign imem.i_readM   = (state_q == S_REQ) && !reset;
  assign if_id_inst     = inst_q;
  assign if_id_pc1      = pc1_q;
  assign if_id_valid    = valid_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    buf_d   = buf_q;
    if (halt) begin
      state_d = S_HALT;
      valid_d = 1'b0;
    end else if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if (redirect) begin
      // Any same-cycle response belongs to the wrong path.
      state_d = S_REQ;
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem.i_inputReady && !stall) begin
            inst_d  = imem.i_data;
            pc1_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end else if (imem.i_inputReady) begin
            buf_d   = imem.i_data;
            pc_d    = pc_inc;
            state_d = S_HOLD;
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            inst_d  = buf_q;
            pc1_d   = pc_q;
            valid_d = 1'b1;
            state_d = S_REQ;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: streaming, latency, stall/HOLD,
// redirect, halt and PC wrap-around.
module tb_if_stage;

  localparam int W = 16;
  localparam logic [W-1:0] K = 16'hA5A5;

  logic         clk;
  logic         reset;
  logic         stall;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         halt;
  logic         rdy;
  logic [W-1:0] if_id_inst;
  logic [W-1:0] if_id_pc1;
  logic         if_id_valid;

  int checks = 0;
  int errors = 0;

  if_stage_if #(.WORD_SIZE(W)) mif ();

  assign mif.i_data       = mif.i_address ^ K;
  assign mif.i_inputReady = rdy;

  if_stage #(.WORD_SIZE(W), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (mif.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .if_id_inst  (if_id_inst),
    .if_id_pc1   (if_id_pc1),
    .if_id_valid (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rdy = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    halt = 1'b0;
    redirect_pc = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    tick();
    checks++;
    if (mif.i_readM !== 1'b0 || mif.i_address !== 16'h0000 ||
        if_id_valid !== 1'b0 || if_id_inst !== 16'h0000 ||
        if_id_pc1 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: readM=%b addr=%h valid=%b inst=%h pc1=%h, want 0 0000 0 0000 0000",
               mif.i_readM, mif.i_address, if_id_valid, if_id_inst, if_id_pc1);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (mif.i_readM !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_readM: got %b want 1", mif.i_readM);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] a;
    do_reset();
    rdy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      a = W'(k - 1);
      checks++;
      if (if_id_valid !== 1'b1 || if_id_pc1 !== W'(k) ||
          if_id_inst !== (a ^ K) || mif.i_address !== W'(k)) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b pc1=%h inst=%h addr=%h, want 1 %h %h %h",
                 k, if_id_valid, if_id_pc1, if_id_inst, mif.i_address,
                 W'(k), a ^ K, W'(k));
      end
    end
    rdy = 1'b0;
  endtask

  task automatic test_latency();
    logic [W-1:0] a;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      a = W'(n);
      rdy = 1'b0;
      for (int j = 0; j < 2; j++) begin
        tick();
        checks++;
        if (if_id_valid !== 1'b0 || mif.i_address !== a ||
            mif.i_readM !== 1'b1) begin
          errors++;
          $display("FAIL latency_wait_%0d_%0d: valid=%b addr=%h readM=%b, want 0 %h 1",
                   n, j, if_id_valid, mif.i_address, mif.i_readM, a);
        end
      end
      rdy = 1'b1;
      tick();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_pc1 !== a + 1'b1 ||
          if_id_inst !== (a ^ K)) begin
        errors++;
        $display("FAIL latency_resp_%0d: valid=%b pc1=%h inst=%h, want 1 %h %h",
                 n, if_id_valid, if_id_pc1, if_id_inst, a + 1'b1, a ^ K);
      end
    end
    rdy = 1'b0;
  endtask

  task automatic test_stall_hold();
    do_reset();
    rdy = 1'b1;
    repeat (5) tick();
    stall = 1'b1;
    tick();
    checks++;
    if (mif.i_readM !== 1'b0 || if_id_pc1 !== 16'h0005 ||
        if_id_inst !== (16'h0004 ^ K) || if_id_valid !== 1'b1 ||
        mif.i_address !== 16'h0006) begin
      errors++;
      $display("FAIL hold_enter: readM=%b pc1=%h inst=%h valid=%b addr=%h, want 0 0005 %h 1 0006",
               mif.i_readM, if_id_pc1, if_id_inst, if_id_valid,
               mif.i_address, 16'h0004 ^ K);
    end
    rdy = 1'b0;
    tick();
    checks++;
    if (mif.i_readM !== 1'b0 || if_id_pc1 !== 16'h0005) begin
      errors++;
      $display("FAIL hold_stay: readM=%b pc1=%h, want 0 0005",
               mif.i_readM, if_id_pc1);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc1 !== 16'h0006 ||
        if_id_inst !== (16'h0005 ^ K) || mif.i_readM !== 1'b1 ||
        mif.i_address !== 16'h0006) begin
      errors++;
      $display("FAIL hold_release: valid=%b pc1=%h inst=%h readM=%b addr=%h, want 1 0006 %h 1 0006",
               if_id_valid, if_id_pc1, if_id_inst, mif.i_readM,
               mif.i_address, 16'h0005 ^ K);
    end
    rdy = 1'b1;
    tick();
    checks++;
    if (if_id_pc1 !== 16'h0007 || if_id_inst !== (16'h0006 ^ K)) begin
      errors++;
      $display("FAIL hold_resume: pc1=%h inst=%h, want 0007 %h",
               if_id_pc1, if_id_inst, 16'h0006 ^ K);
    end
    rdy = 1'b0;
  endtask

  task automatic test_redirect();
    stall = 1'b1;
    rdy = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    checks++;
    if (if_id_valid !== 1'b0 || mif.i_address !== 16'h0040 ||
        mif.i_readM !== 1'b1) begin
      errors++;
      $display("FAIL redirect_req: valid=%b addr=%h readM=%b, want 0 0040 1",
               if_id_valid, mif.i_address, mif.i_readM);
    end
    redirect = 1'b0;
    stall = 1'b0;
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc1 !== 16'h0041 ||
        if_id_inst !== (16'h0040 ^ K)) begin
      errors++;
      $display("FAIL redirect_fetch: valid=%b pc1=%h inst=%h, want 1 0041 %h",
               if_id_valid, if_id_pc1, if_id_inst, 16'h0040 ^ K);
    end
    stall = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0080;
    rdy = 1'b0;
    tick();
    checks++;
    if (if_id_valid !== 1'b0 || mif.i_address !== 16'h0080 ||
        mif.i_readM !== 1'b1) begin
      errors++;
      $display("FAIL redirect_hold: valid=%b addr=%h readM=%b, want 0 0080 1",
               if_id_valid, mif.i_address, mif.i_readM);
    end
    redirect = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    rdy = 1'b1;
    repeat (3) tick();
    halt = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    halt = 1'b0;
    redirect = 1'b0;
    checks++;
    if (mif.i_readM !== 1'b0 || if_id_valid !== 1'b0 ||
        mif.i_address !== 16'h0003) begin
      errors++;
      $display("FAIL halt_enter: readM=%b valid=%b addr=%h, want 0 0 0003",
               mif.i_readM, if_id_valid, mif.i_address);
    end
    for (int i = 0; i < 22; i++) begin
      redirect = (i == 5);
      tick();
      checks++;
      if (mif.i_readM !== 1'b0 || if_id_valid !== 1'b0 ||
          mif.i_address !== 16'h0003) begin
        errors++;
        $display("FAIL halt_stay_%0d: readM=%b valid=%b addr=%h, want 0 0 0003",
                 i, mif.i_readM, if_id_valid, mif.i_address);
      end
    end
    redirect = 1'b0;
    do_reset();
    #1;
    checks++;
    if (mif.i_readM !== 1'b1 || mif.i_address !== 16'h0000) begin
      errors++;
      $display("FAIL halt_exit: readM=%b addr=%h, want 1 0000",
               mif.i_readM, mif.i_address);
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    rdy = 1'b1;
    tick();
    checks++;
    if (if_id_pc1 !== 16'h0000 || if_id_inst !== (16'hFFFF ^ K) ||
        mif.i_address !== 16'h0000 || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_req: pc1=%h inst=%h addr=%h valid=%b, want 0000 %h 0000 1",
               if_id_pc1, if_id_inst, mif.i_address, if_id_valid,
               16'hFFFF ^ K);
    end
    redirect = 1'b1;
    rdy = 1'b0;
    tick();
    redirect = 1'b0;
    rdy = 1'b1;
    stall = 1'b1;
    tick();
    stall = 1'b0;
    rdy = 1'b0;
    tick();
    checks++;
    if (if_id_pc1 !== 16'h0000 || if_id_inst !== (16'hFFFF ^ K) ||
        mif.i_address !== 16'h0000 || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_hold: pc1=%h inst=%h addr=%h valid=%b, want 0000 %h 0000 1",
               if_id_pc1, if_id_inst, mif.i_address, if_id_valid,
               16'hFFFF ^ K);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_stall_hold();
    test_redirect();
    test_halt();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
